rsa_encrypt: RTL and testbench



---
 rtl/rsa_encrypt.sv | 157 +++++++++++++++
 tb/tb_rsa_encrypt.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rsa_encrypt.sv
// RSA encryption engine: c = m^e mod n by left-to-right square-and-multiply,
// with every modular product formed by a bit-serial interleaved shift-add multiplier.
module rsa_encrypt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     m,
    input  logic [2*WIDTH-1:0]   e,
    input  logic [2*WIDTH-1:0]   n,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy,
    output logic                 finish
);

    localparam int unsigned K  = 2 * WIDTH;
    localparam int unsigned CW = $clog2(K);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REDUCE,
        S_SQR,
        S_MUL,
        S_DONE
    } state_e;

    state_e          state_q;
    logic [WIDTH-1:0] m_q;
    logic [K-1:0]    e_q;
    logic [K-1:0]    n_q;
    logic [K-1:0]    acc_q;
    logic [K-1:0]    base_q;
    logic [K-1:0]    r_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   j_q;

    logic [K-1:0]    mm_a;
    logic [K-1:0]    mm_b;
    logic [K:0]      n_ext;
    logic [K:0]      r_sh;
    logic [K:0]      r_red;
    logic [K:0]      r_add;
    logic [K-1:0]    mm_res;
    logic            mm_last;

    // Operand selection: REDUCE forms 1*m mod n, SQR acc*acc, MUL base*acc.
    always_comb begin
        mm_a = base_q;
        mm_b = acc_q;
        unique case (state_q)
            S_REDUCE: begin
                mm_a = K'(1);
                mm_b = K'(m_q);
            end
            S_SQR: begin
                mm_a = acc_q;
                mm_b = acc_q;
            end
            default: begin
                mm_a = base_q;
                mm_b = acc_q;
            end
        endcase
    end

    // One interleaved iteration; r < n on entry keeps every intermediate within K+1 bits.
    always_comb begin
        n_ext = {1'b0, n_q};
        r_sh  = {r_q, 1'b0};
        r_red = (r_sh >= n_ext) ? (r_sh - n_ext) : r_sh;
        r_add = mm_b[cnt_q] ? (r_red + {1'b0, mm_a}) : r_red;
        mm_res = (r_add >= n_ext) ? K'(r_add - n_ext) : K'(r_add);
        mm_last = (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            j_q     <= '0;
            c       <= '0;
            busy    <= 1'b0;
            finish  <= 1'b0;
        end else begin
            finish <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        m_q     <= m;
                        e_q     <= e;
                        n_q     <= n;
                        busy    <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_q   <= '0;
                    cnt_q <= CW'(K - 1);
                    j_q   <= CW'(K - 1);
                    if (n_q < K'(2)) begin
                        acc_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        acc_q   <= K'(1);
                        state_q <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    r_q   <= mm_res;
                    cnt_q <= cnt_q - CW'(1);
                    if (mm_last) begin
                        base_q  <= mm_res;
                        r_q     <= '0;
                        cnt_q   <= CW'(K - 1);
                        state_q <= S_SQR;
                    end
                end
                S_SQR, S_MUL: begin
                    r_q   <= mm_res;
                    cnt_q <= cnt_q - CW'(1);
                    if (mm_last) begin
                        acc_q <= mm_res;
                        r_q   <= '0;
                        cnt_q <= CW'(K - 1);
                        // Exponent step is folded into the final product cycle.
                        if (state_q == S_SQR && e_q[j_q]) begin
                            state_q <= S_MUL;
                        end else if (j_q == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            j_q     <= j_q - CW'(1);
                            state_q <= S_SQR;
                        end
                    end
                end
                S_DONE: begin
                    c       <= acc_q;
                    finish  <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_encrypt.sv
// Directed bench for rsa_encrypt: scoreboarded results and latencies, handshake,
// abort-by-reset and a WIDTH=12 round trip.
module tb_rsa_encrypt;

    logic        clk;
    logic        rst;
    logic        start8;
    logic [7:0]  m8;
    logic [15:0] e8;
    logic [15:0] n8;
    logic [15:0] c8;
    logic        busy8;
    logic        finish8;

    logic        start12;
    logic [11:0] m12;
    logic [23:0] e12;
    logic [23:0] n12;
    logic [23:0] c12;
    logic        busy12;
    logic        finish12;

    int n_vec;
    int n_err;
    int unsigned q_c[$];
    int unsigned q_l[$];

    rsa_encrypt #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .m(m8), .e(e8), .n(n8),
        .c(c8), .busy(busy8), .finish(finish8)
    );

    rsa_encrypt #(.WIDTH(12)) dut12 (
        .clk(clk), .rst(rst), .start(start12), .m(m12), .e(e12), .n(n12),
        .c(c12), .busy(busy12), .finish(finish12)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Right-to-left exponentiation on 64-bit integers, 16 exponent bits.
    function automatic int unsigned model_c(input int unsigned mm, input int unsigned ee,
                                            input int unsigned nn);
        longint unsigned r;
        longint unsigned b;
        if (nn < 2) return 0;
        r = 1;
        b = longint'(mm % nn);
        for (int i = 0; i < 16; i++) begin
            if (ee[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return 32'(r);
    endfunction

    function automatic int unsigned model_l(input int unsigned ee, input int unsigned nn);
        logic [15:0] e16;
        e16 = 16'(ee);
        if (nn < 2) return 2;
        return 2 + 16 * (1 + 16 + $countones(e16));
    endfunction

    // mode 0: plain; 1: start pulses and operand changes while busy and in DONE; 2: reset at cycle 100
    task automatic go(input int unsigned mm, input int unsigned ee, input int unsigned nn,
                      input int mode, input string tag);
        int unsigned exp_c;
        int unsigned exp_l;
        int          k;
        bit          busy_bad;
        bit          done;
        q_c.push_back(model_c(mm, ee, nn));
        q_l.push_back(model_l(ee, nn));
        m8 = 8'(mm);
        e8 = 16'(ee);
        n8 = 16'(nn);
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8   = 1'b0;
        busy_bad = !busy8;
        k        = 0;
        done     = 1'b0;
        while (!done && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
            if (mode == 2 && k == 100) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check({tag, "_busy"}, busy8, 0);
                check({tag, "_c"}, c8, 0);
                check({tag, "_finish"}, finish8, 0);
                void'(q_c.pop_front());
                void'(q_l.pop_front());
                return;
            end
            if (finish8) done = 1'b1;
            else if (!busy8) busy_bad = 1'b1;
            if (mode == 1) begin
                if (k == 50) begin
                    start8 = 1'b1;
                    m8 = 8'($urandom);
                    e8 = 16'($urandom);
                    n8 = 16'($urandom);
                end
                if (k == 51) start8 = 1'b0;
                if (k == int'(model_l(ee, nn)) - 1) start8 = 1'b1;
                if (done) start8 = 1'b0;
            end
        end
        exp_c = q_c.pop_front();
        exp_l = q_l.pop_front();
        check({tag, "_finished"}, done, 1);
        check({tag, "_latency"}, k, exp_l);
        check({tag, "_c"}, c8, exp_c);
        check({tag, "_busy_window"}, busy_bad, 0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {busy8, finish8}, 0);
        check({tag, "_hold"}, c8, exp_c);
    endtask

    initial begin
        int k;
        clk = 1'b0;
        rst = 1'b1;
        n_vec = 0;
        n_err = 0;
        start8 = 1'b0; m8 = '0; e8 = '0; n8 = '0;
        start12 = 1'b0; m12 = '0; e12 = '0; n12 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c", c8, 0);
        check("rst_busy", busy8, 0);
        check("rst_finish", finish8, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        go(65, 17, 3233, 0, "enc65");
        check("enc65_const", c8, 2790);
        check("enc65_const_lat", model_l(17, 3233), 306);
        go(200, 7, 143, 0, "m_ge_n");
        check("m_ge_n_const", c8, 73);
        go(65, 0, 3233, 0, "e_zero");
        check("e_zero_const", c8, 1);
        go(77, 12345, 1, 0, "n_one");
        go(200, 255, 0, 0, "n_zero");
        go(255, 16'hffff, 16'hfffb, 0, "all_ones");
        for (int i = 1; i <= 31; i++) begin
            go(65, i, 3233, 0, $sformatf("sweep_e%0d", i));
        end
        go(65, 17, 3233, 1, "disturb");
        go(65, 17, 3233, 2, "abort");
        go(65, 17, 3233, 0, "restart");

        // Wider build: decrypt the ciphertext back to the plaintext.
        m12 = 12'd2790;
        e12 = 24'd2753;
        n12 = 24'd3233;
        start12 = 1'b1;
        @(posedge clk);
        #1;
        start12 = 1'b0;
        k = 0;
        while (!finish12 && k < 5000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("w12_finished", finish12, 1);
        check("w12_roundtrip", c12, 65);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
